// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: turns EX/MEM control into a request/acknowledge
// transaction with a variable-latency data memory and registers the MEM/WB results.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemToRegM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic        AlignErrW,
    output logic        BusErrW
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t     state;
    logic [7:0] cnt;

    logic memop, misal, access, inWait, atLimit, abort, ackd, alignErr, err;

    assign memop    = MemWriteM | MemToRegM;
    assign misal    = memop & (ALUOutM[1:0] != 2'b00);
    assign access   = memop & ~misal;
    assign inWait   = (state == WAIT);
    assign atLimit  = (cnt == TimeoutCnt);
    // An ack arriving in the limit cycle still completes the access normally.
    assign abort    = inWait & ~mem_ack & atLimit;

    assign mem_req  = ~reset & (inWait ? ~abort : access);
    assign StallM   = ~reset & ~mem_ack & (inWait ? ~atLimit : access);
    assign mem_we   = MemWriteM;
    assign mem_addr = ALUOutM;
    assign mem_wdata = WriteDataM;

    // An ack without an outstanding request carries no data and is ignored.
    assign ackd     = mem_req & mem_ack;
    assign alignErr = ~inWait & misal;
    assign err      = alignErr | abort;

    // NOTE: reset is sampled on the clock edge only, so it belongs inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            ReadDataW <= 32'd0;
            ALUOutW   <= 32'd0;
            WriteRegW <= 5'd0;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            AlignErrW <= 1'b0;
            BusErrW   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !mem_ack) begin
                        state <= WAIT;
                        cnt   <= 8'd1;
                    end
                end
                WAIT: begin
                    if (mem_ack || atLimit) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase

            // A stalled cycle pushes a bubble into MEM/WB; otherwise the instruction completes.
            if (StallM) begin
                ReadDataW <= 32'd0;
                ALUOutW   <= 32'd0;
                WriteRegW <= 5'd0;
                RegWriteW <= 1'b0;
                MemToRegW <= 1'b0;
                AlignErrW <= 1'b0;
                BusErrW   <= 1'b0;
            end else begin
                ReadDataW <= (MemToRegM & ackd) ? mem_rdata : 32'd0;
                ALUOutW   <= ALUOutM;
                WriteRegW <= WriteRegM;
                RegWriteW <= RegWriteM & ~err;
                MemToRegW <= MemToRegM & ~err;
                AlignErrW <= alignErr;
                BusErrW   <= abort;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// instructions checked against a per-instruction latency/outcome model.
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;
    localparam int NO_ACK  = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        RegWriteM, MemWriteM, MemToRegM;
    logic        mem_req, mem_we, mem_ack, StallM;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;
    logic        RegWriteW, MemToRegW, AlignErrW, BusErrW;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .StallM(StallM),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .AlignErrW(AlignErrW), .BusErrW(BusErrW)
    );

    logic [72:0] wOut;
    assign wOut = {ReadDataW, ALUOutW, WriteRegW, RegWriteW, MemToRegW, AlignErrW, BusErrW};

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wreg,
                         input logic rw, input logic mw, input logic mtr);
        ALUOutM    = addr;
        WriteDataM = wdata;
        WriteRegM  = wreg;
        RegWriteM  = rw;
        MemWriteM  = mw;
        MemToRegM  = mtr;
    endtask

    // lat: cycles after the first request cycle at which ack is given (NO_ACK = never).
    task automatic run_instr(input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wreg,
                             input logic rw, input logic mw, input logic mtr,
                             input int lat, input logic [31:0] rdata);
        logic memop, misal, access, busErr, ackd, err;
        int stall;
        logic [72:0] expW;
        memop  = mw | mtr;
        misal  = memop && (addr[1:0] != 2'b00);
        access = memop && !misal;
        stall  = access ? ((lat < TIMEOUT) ? lat : TIMEOUT) : 0;
        busErr = access && (lat > TIMEOUT);
        ackd   = access && !busErr;
        err    = misal | busErr;
        expW   = {(mtr && ackd) ? rdata : 32'h0, addr, wreg, rw & ~err, mtr & ~err, misal, busErr};
        for (int cyc = 0; cyc <= stall; cyc++) begin
            @(negedge clk);
            drive(addr, wdata, wreg, rw, mw, mtr);
            mem_ack   = (cyc == lat);
            mem_rdata = (cyc == lat) ? rdata : $urandom;
            #1;
            check("mem_req", 96'(mem_req), 96'(access && !(busErr && cyc == TIMEOUT)));
            check("StallM", 96'(StallM), 96'(cyc < stall));
            if (access)
                check("mem_bus", 96'({mem_we, mem_addr, mem_wdata}), 96'({mw, addr, wdata}));
            @(posedge clk);
            #1;
            if (cyc < stall) check("W_bubble", 96'(wOut), 96'(0));
            else             check("W_result", 96'(wOut), 96'(expW));
        end
    endtask

    initial begin
        logic [31:0] addr;
        int op, lat;

        // Reset held for two cycles with an aligned load on the M inputs.
        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        drive(32'h100, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_mem_req", 96'(mem_req), 96'(0));
            check("rst_StallM", 96'(StallM), 96'(0));
            check("rst_W", 96'(wOut), 96'(0));
        end
        reset = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        run_instr(32'h100, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 0, 32'hDEADBEEF);  // zero-wait load
        run_instr(32'h40, 32'h1234, 5'd0, 1'b0, 1'b1, 1'b0, 3, 32'h55AA55AA); // 3-cycle store
        run_instr(32'h102, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 0, 32'hCAFEF00D);  // misaligned load
        run_instr(32'h200, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, NO_ACK, 32'h0);   // timeout
        run_instr(32'h7, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 0, 32'h0);          // ALU op after abort
        run_instr(32'h300, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, TIMEOUT, 32'h0BADF00D); // ack in limit cycle

        // Reset asserted in the second stall cycle.
        @(negedge clk);
        drive(32'h400, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1);
        mem_ack = 1'b0;
        #1;
        check("rw_stall1", 96'(StallM), 96'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rw_mem_req", 96'(mem_req), 96'(0));
        check("rw_StallM", 96'(StallM), 96'(0));
        @(posedge clk);
        #1;
        check("rw_W", 96'(wOut), 96'(0));
        @(negedge clk);
        reset = 1'b0;
        run_instr(32'h404, 32'h0, 5'd14, 1'b1, 1'b0, 1'b1, 0, 32'h13579BDF);
        run_instr(32'h408, 32'h0, 5'd15, 1'b1, 1'b0, 1'b1, NO_ACK, 32'h0);

        for (int i = 0; i < 300; i++) begin
            op   = $urandom_range(0, 2);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            lat  = $urandom_range(0, TIMEOUT + 2);
            case (op)
                0: run_instr(addr, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, lat, $urandom);
                1: run_instr(addr, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b1, lat, $urandom);
                default: run_instr(addr, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b0, lat, $urandom);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
